aes_inv_top: RTL
================

AES_INV_TOP -- requirements
Module: aes_inv_top

Interface
REQ-001 SHALL have ports: AES_clk input 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have ports: AES_rst_n input 1, asynchronous active-low reset.
REQ-003 SHALL have ports: AES_en input 1, start request, sampled only in IDLE.
REQ-004 SHALL have ports: AES_data_in input 128, ciphertext, byte 0 in bits [127:120].
REQ-005 SHALL have ports: AES_key_in input 128, AES-128 cipher key with the same byte order.
REQ-006 SHALL have ports: AES_data_out output 128, recovered plaintext.
REQ-007 SHALL have ports: AES_data_out_valid output 1, one-cycle result strobe.
REQ-008 SHALL have ports: AES_busy output 1, high while in KEYEXP or ROUND.

Function
REQ-009 SHALL implement FIPS-197 AES-128 decryption (InvCipher), iterative, one operation step per clock.
REQ-010 SHALL use states IDLE, KEYEXP, ROUND; IDLE -> KEYEXP when AES_en=1; KEYEXP -> ROUND after 10 cycles; ROUND -> IDLE after 10 cycles.
REQ-011 SHALL latch AES_data_in and AES_key_in at the accepting edge (edge 0); later input changes do not affect the running operation.
REQ-012 KEYEXP edges 1..10 SHALL step the forward key schedule (Rcon 01..36); edge 10 also loads state = ciphertext XOR rk10.
REQ-013 ROUND edges 11..20 SHALL apply InvShiftRows, InvSubBytes, XOR rk(10-r), then InvMixColumns; InvMixColumns is omitted in round 10.
REQ-014 Round keys SHALL be derived backwards on the fly (inverse key step, Rcon halved in GF(2^8)); no 11-key storage.
REQ-015 Edge 20 SHALL load AES_data_out with the plaintext, assert AES_data_out_valid for exactly one cycle, and return to IDLE.
REQ-016 Latency SHALL be 20 cycles from the accepting edge to valid high; throughput SHALL be 1 block per 21 cycles.
REQ-017 AES_en SHALL be ignored while busy, including at edge 20; AES_en held high SHALL start the next block at edge 21.
REQ-018 AES_data_out SHALL hold the last result until the next completion.

Reset
REQ-019 Reset assertion SHALL immediately force IDLE, AES_data_out=0, AES_data_out_valid=0, AES_busy=0, and clear the internal state, key and counter.
REQ-020 Reset mid-operation SHALL abort the block with no valid strobe; the first AES_en after release starts a clean operation.

Configuration
REQ-021 With AES_INV_COMPLEMENT_EN defined, the block SHALL add outputs AES_data_out_complementary (128) = ~AES_data_out and AES_data_out_complementary_valid, which is cycle-identical to AES_data_out_valid; both reset to 0.
REQ-022 Without AES_INV_COMPLEMENT_EN, those ports and their registers SHALL be absent.

Structure
REQ-023 Shared package aes_pkg SHALL hold the forward and inverse S-box functions, xtime and inverse-xtime, the Rcon first/last constants, the state enum and the round count (10).
REQ-024 A combinational sub-module aes_inv_round SHALL take the state, round key and last-round flag and return the next state.

Verification
REQ-025 Test 1: key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> data_out 00112233445566778899aabbccddeeff, valid 20 cycles after acceptance.
REQ-026 Test 2: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32 -> data_out 3243f6a8885a308d313198a2e0370734.
REQ-027 Test 3: during Test 1, change data_in/key_in and pulse AES_en at cycle 5 -> same result, no second start, exactly one valid.
REQ-028 Test 4: hold AES_en high with the Test 1 vectors -> valid at cycles 20, 41, 62, each with the Test 1 plaintext.
REQ-029 Test 5: assert AES_rst_n low at cycle 12 -> outputs 0 at once, no valid; rerun Test 2 after release -> correct plaintext.
REQ-030 Test 6: with AES_INV_COMPLEMENT_EN defined, Test 1 -> complementary output ffeeddccbbaa99887766554433221100, valid coincident with AES_data_out_valid.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-boxes, GF(2^8) helpers, key-schedule steps, FSM enum.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned BLK_W      = 128;
  localparam logic [7:0]  RCON_FIRST = 8'h01;
  localparam logic [7:0]  RCON_LAST  = 8'h36;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    ROUND  = 2'd2
  } aes_state_e;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry x sits at bits 8*(255-x)+7 down, i.e. index {~x,3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TBL[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Division by x in GF(2^8): undoes xtime.
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return x[0] ? {1'b1, x[7:1] ^ 7'h0d} : {1'b0, x[7:1]};
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w, input logic [7:0] rc);
    return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w0 = w0 ^ sub_rot(w3, rc);
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3, p0, p1, p2, p3;
    {n0, n1, n2, n3} = k;
    p3 = n3 ^ n2;
    p2 = n2 ^ n1;
    p1 = n1 ^ n0;
    p0 = n0 ^ sub_rot(p3, rc);
    return {p0, p1, p2, p3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One InvCipher round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns (skipped on last).
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         last_i,
  output logic [127:0] state_c
);

  logic [127:0] sub_s;
  logic [127:0] add_s;
  logic [127:0] mix_s;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[8*(3-i) +: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Byte i = row + 4*col lives at bits [8*(15-i) +: 8]; row r rotates right by r.
  always_comb begin
    sub_s = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub_s[8*(15-(r+4*c)) +: 8] = inv_sbox(state_i[8*(15-(r+4*((c-r+4)%4))) +: 8]);
      end
    end
    add_s = sub_s ^ rk_i;
    mix_s = '0;
    for (int c = 0; c < 4; c++) begin
      mix_s[32*(3-c) +: 32] = inv_mix_col(add_s[32*(3-c) +: 32]);
    end
    state_c = last_i ? add_s : mix_s;
  end

endmodule

// File: rtl/aes_inv_top.sv
// Iterative AES-128 decryptor: 10-cycle forward key expansion, then 10 rounds with backward keys.
// Optional AES_INV_COMPLEMENT_EN adds a complemented copy of the result and its strobe.
module aes_inv_top
  import aes_pkg::*;
(
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid,
  output logic         AES_busy
`ifdef AES_INV_COMPLEMENT_EN
  ,
  output logic [127:0] AES_data_out_complementary,
  output logic         AES_data_out_complementary_valid
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ROUNDS - 1);

  aes_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] key_q, key_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [7:0]       rcon_q, rcon_d;
  logic [BLK_W-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic [BLK_W-1:0] key_next_c;
  logic [BLK_W-1:0] rk_prev_c;
  logic [BLK_W-1:0] round_c;
  logic             last_c;

  assign key_next_c = key_fwd(key_q, rcon_q);
  assign rk_prev_c  = key_inv(key_q, rcon_q);
  assign last_c     = (cnt_q == LAST_CNT);

  aes_inv_round u_round (
    .state_i (blk_q),
    .rk_i    (rk_prev_c),
    .last_i  (last_c),
    .state_c (round_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    blk_d   = blk_q;
    rcon_d  = rcon_q;
    out_d   = out_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (AES_en) begin
          key_d   = AES_key_in;
          blk_d   = AES_data_in;
          cnt_d   = '0;
          rcon_d  = RCON_FIRST;
          busy_d  = 1'b1;
          state_d = KEYEXP;
        end
      end
      KEYEXP: begin
        key_d = key_next_c;
        cnt_d = cnt_q + CNT_W'(1);
        rcon_d = xtime(rcon_q);
        // Last expansion step: rcon stays at 0x36, which seeds the backward walk.
        if (last_c) begin
          rcon_d  = rcon_q;
          blk_d   = blk_q ^ key_next_c;
          cnt_d   = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        key_d  = rk_prev_c;
        blk_d  = round_c;
        rcon_d = inv_xtime(rcon_q);
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_c) begin
          out_d   = round_c;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      blk_q   <= '0;
      rcon_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      blk_q   <= blk_d;
      rcon_q  <= rcon_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign AES_data_out       = out_q;
  assign AES_data_out_valid = valid_q;
  assign AES_busy           = busy_q;

`ifdef AES_INV_COMPLEMENT_EN
  logic [BLK_W-1:0] comp_q, comp_d;
  logic             comp_valid_q, comp_valid_d;

  // Updated only on completion so the reset value stays 0 until the first result.
  always_comb begin
    comp_d       = valid_d ? ~out_d : comp_q;
    comp_valid_d = valid_d;
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      comp_q       <= '0;
      comp_valid_q <= 1'b0;
    end else begin
      comp_q       <= comp_d;
      comp_valid_q <= comp_valid_d;
    end
  end

  assign AES_data_out_complementary       = comp_q;
  assign AES_data_out_complementary_valid = comp_valid_q;
`endif

endmodule
